// File: rtl/cart_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cart_loader_if
//  Description : HPS ioctl download bundle for the BALLY cartridge loader.
//                Signals: I_DOWNLOAD (download active), I_INDEX (image index),
//                I_WR (one-cycle word strobe), I_ADDR (even byte address),
//                I_DATA (16-bit word, low byte at I_ADDR), O_WAIT (stall).
//                master = HPS side, slave = loader side.
//  Revision    : 1.0  initial release
// ============================================================================
interface cart_loader_if;
    logic        I_DOWNLOAD;
    logic [7:0]  I_INDEX;
    logic        I_WR;
    logic [24:0] I_ADDR;
    logic [15:0] I_DATA;
    logic        O_WAIT;

    modport master (output I_DOWNLOAD, I_INDEX, I_WR, I_ADDR, I_DATA,
                    input  O_WAIT);
    modport slave  (input  I_DOWNLOAD, I_INDEX, I_WR, I_ADDR, I_DATA,
                    output O_WAIT);
endinterface
`default_nettype wire

// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cart_loader
//  Description : Loads a BALLY cartridge image from the HPS ioctl port into a
//                byte-wide dpram, splitting each 16-bit word into two byte
//                writes while stalling the HPS. Tracks image size, derives a
//                power-of-two mirror mask and serves the cart read path.
//  Ports       : CLK, I_RESET_L (async active-low), ioctl (download bundle),
//                I_CAS_ADDR/O_CAS_DATA (BALLY read), O_ROM_* / I_ROM_Q (dpram),
//                O_SIZE, O_LOADED, O_OVERFLOW (status).
//  Revision    : 1.0  initial release
// ============================================================================
module cart_loader #(
    parameter int AW    = 13,
    parameter int INDEX = 1
) (
    input  wire logic          CLK,
    input  wire logic          I_RESET_L,
    cart_loader_if.slave       ioctl,
    input  wire logic [AW-1:0] I_CAS_ADDR,
    output logic      [7:0]    O_CAS_DATA,
    output logic      [AW-1:0] O_ROM_ADDR,
    output logic      [7:0]    O_ROM_DATA,
    output logic               O_ROM_WE,
    input  wire logic [7:0]    I_ROM_Q,
    output logic      [AW:0]   O_SIZE,
    output logic               O_LOADED,
    output logic               O_OVERFLOW
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q;
    logic          end_pend_q, end_pend_d;
    logic [15:0]   word_q, word_d;
    logic [AW-1:0] base_q, base_d;
    logic          wait_q, wait_d;
    logic [AW:0]   size_q, size_d;
    logic          loaded_q, loaded_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] mask_q, mask_d;
    logic          rd_flag_q;

    logic          sel_w, start_w, end_w;
    logic [AW:0]   size_base_w, top_w;
    logic [AW-1:0] mask_calc_w;
    logic [AW-1:0] wr_addr_w;

    assign sel_w   = ioctl.I_DOWNLOAD && (ioctl.I_INDEX == 8'(INDEX));
    assign start_w = sel_w && !sel_q;
    assign end_w   = !sel_w && sel_q;

    // Smallest power of two covering the image, never below a quarter window.
    always_comb begin
        mask_calc_w = AW'((32'd1 << (AW - 2)) - 32'd1);
        for (int k = AW - 2; k < AW; k++) begin
            if (size_q > ((AW+1)'(1) << k))
                mask_calc_w = AW'((32'd1 << (k + 1)) - 32'd1);
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        base_d     = base_q;
        wait_d     = wait_q;
        mask_d     = mask_q;
        end_pend_d = start_w ? 1'b0 : (end_pend_q || end_w);
        // A download start clears status on the same edge as any accepted write.
        size_base_w = start_w ? '0 : size_q;
        size_d      = size_base_w;
        loaded_d    = start_w ? 1'b0 : loaded_q;
        ovf_d       = start_w ? 1'b0 : ovf_q;
        top_w       = {1'b0, base_q} + (AW+1)'(2);

        case (state_q)
            IDLE: begin
                if (ioctl.I_WR && sel_w) begin
                    if (ioctl.I_ADDR[24:AW] == '0) begin
                        word_d  = ioctl.I_DATA;
                        base_d  = ioctl.I_ADDR[AW-1:0];
                        wait_d  = 1'b1;
                        state_d = WR_LO;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // End processing waits until the final word has fully landed.
                if (end_pend_q && !start_w) begin
                    loaded_d   = (size_q != '0);
                    mask_d     = mask_calc_w;
                    end_pend_d = 1'b0;
                end
            end
            WR_LO: state_d = WR_HI;
            WR_HI: begin
                if (top_w > size_base_w)
                    size_d = top_w;
                wait_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                wait_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            end_pend_q <= 1'b0;
            word_q     <= '0;
            base_q     <= '0;
            wait_q     <= 1'b0;
            size_q     <= '0;
            loaded_q   <= 1'b0;
            ovf_q      <= 1'b0;
            mask_q     <= '1;
            rd_flag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_w;
            end_pend_q <= end_pend_d;
            word_q     <= word_d;
            base_q     <= base_d;
            wait_q     <= wait_d;
            size_q     <= size_d;
            loaded_q   <= loaded_d;
            ovf_q      <= ovf_d;
            mask_q     <= mask_d;
            // Delayed one cycle to line up with the dpram read latency.
            rd_flag_q  <= loaded_q && !sel_w;
        end
    end

    assign wr_addr_w  = (state_q == WR_HI) ? base_q + AW'(1) : base_q;
    assign O_ROM_WE   = (state_q == WR_LO) || (state_q == WR_HI);
    assign O_ROM_DATA = (state_q == WR_HI) ? word_q[15:8] : word_q[7:0];
    assign O_ROM_ADDR = ((state_q != IDLE) || sel_w) ? wr_addr_w
                                                     : (I_CAS_ADDR & mask_q);
    assign O_CAS_DATA = rd_flag_q ? I_ROM_Q : 8'hFF;
    assign ioctl.O_WAIT = wait_q;
    assign O_SIZE     = size_q;
    assign O_LOADED   = loaded_q;
    assign O_OVERFLOW = ovf_q;

endmodule
`default_nettype wire
